fir_l3_output_serializer: RTL and testbench



---
 rtl/fir_l3_output_serializer_if.sv | 27 ++
 rtl/fir_l3_output_serializer.sv | 135 +++++++++++++
 tb/tb_fir_l3_output_serializer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_l3_output_serializer_if.sv
// Handshake bundle between the L=3 FIR block output and the serial audio sink.
// The slave view belongs to the serializer; the master view drives it.
interface fir_l3_output_serializer_if #(
   parameter int DATA_IN_WIDTH  = 64,
   parameter int DATA_OUT_WIDTH = 16
);
   logic                             in_valid;
   logic                             in_ready;
   logic signed [DATA_IN_WIDTH-1:0]  data_in_1;
   logic signed [DATA_IN_WIDTH-1:0]  data_in_2;
   logic signed [DATA_IN_WIDTH-1:0]  data_in_3;
   logic                             out_valid;
   logic                             out_ready;
   logic signed [DATA_OUT_WIDTH-1:0] data_out;
   logic [1:0]                       out_lane;
   logic [15:0]                      sat_count;

   modport master (
      output in_valid, data_in_1, data_in_2, data_in_3, out_ready,
      input  in_ready, out_valid, data_out, out_lane, sat_count
   );

   modport slave (
      input  in_valid, data_in_1, data_in_2, data_in_3, out_ready,
      output in_ready, out_valid, data_out, out_lane, sat_count
   );
endinterface

// File: rtl/fir_l3_output_serializer.sv
// Rounds/saturates three parallel FIR lanes to 16-bit samples, buffers them as
// blocks in a small FIFO and emits them serially in lane order 0,1,2.
module fir_l3_output_serializer #(
   parameter int DATA_IN_WIDTH  = 64,
   parameter int DATA_OUT_WIDTH = 16,
   parameter int SHIFT          = 31,
   parameter int BLOCK_DEPTH    = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   fir_l3_output_serializer_if.slave   bus
);
   localparam int AW = $clog2(BLOCK_DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = 3 * DATA_OUT_WIDTH;

   localparam logic signed [DATA_IN_WIDTH:0] HALF    = {{DATA_IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
   localparam logic signed [DATA_IN_WIDTH:0] SAT_MAX = (DATA_IN_WIDTH+1)'((1 << (DATA_OUT_WIDTH - 1)) - 1);
   localparam logic signed [DATA_IN_WIDTH:0] SAT_MIN = ~SAT_MAX;
   localparam logic [DATA_OUT_WIDTH-1:0]     OUT_MAX = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
   localparam logic [DATA_OUT_WIDTH-1:0]     OUT_MIN = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};

   typedef enum logic {ST_EMPTY, ST_EMIT} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [1:0]       lane_q, lane_d;
   logic [15:0]      sat_count_q, sat_count_d;
   logic [EW-1:0]    mem_q [BLOCK_DEPTH];

   logic signed [DATA_IN_WIDTH-1:0] lane_in [3];
   logic [EW-1:0]    quant_word;
   logic [2:0]       sat_flags;
   logic [PW-1:0]    count;
   logic             full, empty, push;
   logic [EW-1:0]    head;
   logic [16:0]      sat_sum;

   assign lane_in[0] = bus.data_in_1;
   assign lane_in[1] = bus.data_in_2;
   assign lane_in[2] = bus.data_in_3;

   // One extra bit of headroom keeps +0.5 from wrapping at the positive extreme.
   for (genvar gi = 0; gi < 3; gi++) begin : g_quant
      logic signed [DATA_IN_WIDTH:0] sum;
      logic signed [DATA_IN_WIDTH:0] shifted;
      assign sum     = $signed({lane_in[gi][DATA_IN_WIDTH-1], lane_in[gi]}) + HALF;
      assign shifted = sum >>> SHIFT;
      assign sat_flags[gi] = (shifted > SAT_MAX) || (shifted < SAT_MIN);
      assign quant_word[gi*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] =
         (shifted > SAT_MAX) ? OUT_MAX :
         (shifted < SAT_MIN) ? OUT_MIN : shifted[DATA_OUT_WIDTH-1:0];
   end

   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = bus.in_valid && !full;
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   assign sat_sum     = {1'b0, sat_count_q} + 17'({1'b0, sat_flags[0]} + {1'b0, sat_flags[1]} + {1'b0, sat_flags[2]});
   assign sat_count_d = !push ? sat_count_q : (sat_sum[16] ? 16'hFFFF : sat_sum[15:0]);

   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      case (state_q)
         ST_EMPTY: begin
            lane_d = 2'd0;
            // Entering on the push edge itself gives one-cycle latency.
            if (!empty || push) begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (bus.out_ready) begin
               if (lane_q == 2'd2) begin
                  lane_d   = 2'd0;
                  rd_ptr_d = rd_ptr_q + PW'(1);
                  if ((count == PW'(1)) && !push) begin
                     state_d = ST_EMPTY;
                  end
               end else begin
                  lane_d = lane_q + 2'd1;
               end
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_EMPTY;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         lane_q      <= 2'd0;
         sat_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         lane_q      <= lane_d;
         sat_count_q <= sat_count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= quant_word;
      end
   end

   always_comb begin
      bus.data_out = '0;
      if (state_q == ST_EMIT) begin
         case (lane_q)
            2'd0:    bus.data_out = head[0*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
            2'd1:    bus.data_out = head[1*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
            default: bus.data_out = head[2*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
         endcase
      end
   end

   assign bus.in_ready  = !full;
   assign bus.out_valid = (state_q == ST_EMIT);
   assign bus.out_lane  = lane_q;
   assign bus.sat_count = sat_count_q;
endmodule

// File: tb/tb_fir_l3_output_serializer.sv
// Scoreboard bench for the L=3 output serializer: stimulus queues expected
// samples from a plain-arithmetic model, a negedge monitor pops and compares.
module tb_fir_l3_output_serializer;
   localparam int IW = 64;
   localparam int OW = 16;
   localparam int SH = 31;
   localparam int BD = 2;

   typedef struct packed {
      logic signed [OW-1:0] data;
      logic [1:0]           lane;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fir_l3_output_serializer_if #(.DATA_IN_WIDTH(IW), .DATA_OUT_WIDTH(OW)) bus ();

   fir_l3_output_serializer #(
      .DATA_IN_WIDTH(IW), .DATA_OUT_WIDTH(OW), .SHIFT(SH), .BLOCK_DEPTH(BD)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_sat  = 0;
   bit   rand_ready  = 1'b0;
   bit   ready_force = 1'b1;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Round-half-up of x / 2^SH, computed as floor((x + 2^(SH-1)) / 2^SH).
   function automatic longint quant_raw(input longint x);
      logic signed [127:0] v, d, q;
      v = x;
      v = v + (128'sd1 <<< (SH - 1));
      d = 128'sd1 <<< SH;
      q = v / d;
      if (((v % d) != 0) && (v < 0)) q = q - 1;
      return longint'(q);
   endfunction

   function automatic longint clamp16(input longint r);
      if (r > 32767)  return 32767;
      if (r < -32768) return -32768;
      return r;
   endfunction

   function automatic int is_sat(input longint r);
      return ((r > 32767) || (r < -32768)) ? 1 : 0;
   endfunction

   // One input cycle: present a block (or idle), record it in the scoreboard if accepted.
   task automatic drive_cycle(input bit v, input longint a, input longint b, input longint c,
                              input bit use_exp, input longint e1, input longint e2,
                              input longint e3, output bit acc);
      longint vals [3];
      longint exps [3];
      exp_t   e;
      vals = '{a, b, c};
      exps = '{e1, e2, e3};
      bus.in_valid  = v;
      bus.data_in_1 = a;
      bus.data_in_2 = b;
      bus.data_in_3 = c;
      @(negedge clk);
      acc = v && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
         for (int i = 0; i < 3; i++) begin
            e.data = use_exp ? OW'(exps[i]) : OW'(clamp16(quant_raw(vals[i])));
            e.lane = 2'(i);
            exp_q.push_back(e);
            exp_sat = exp_sat + is_sat(quant_raw(vals[i]));
         end
         if (exp_sat > 65535) exp_sat = 65535;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      repeat (n) drive_cycle(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, acc);
   endtask

   task automatic drain();
      int budget = 300;
      while ((exp_q.size() != 0) && (budget > 0)) begin
         idle(1);
         budget--;
      end
      check("drain_timeout", exp_q.size(), 0);
   endtask

   function automatic longint rand_val();
      longint k, frac;
      k = longint'($urandom_range(0, 80000)) - 40000;
      case ($urandom_range(0, 3))
         0: return (k <<< SH) + longint'($urandom_range(0, 32'h7FFF_FFFF));
         1: return (k <<< SH) + 64'sh4000_0000;
         2: return {$urandom, $urandom};
         default: begin
            frac = longint'($urandom_range(0, 32'hFFFF_FFFF)) - (64'sd1 <<< SH);
            k    = (64'sd32767 <<< SH) + frac;
            return ($urandom_range(0, 1) != 0) ? -k : k;
         end
      endcase
   endfunction

   always @(posedge clk) begin
      #1;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("in_ready", longint'(bus.in_ready), longint'(((exp_q.size() + 2) / 3) < BD));
         check("out_valid", longint'(bus.out_valid), longint'(exp_q.size() != 0));
         if (bus.out_valid && (exp_q.size() != 0)) begin
            check("data_out", longint'(bus.data_out), longint'(exp_q[0].data));
            check("out_lane", longint'(bus.out_lane), longint'(exp_q[0].lane));
            if (bus.out_ready) begin
               $display("sample lane=%0d data=%0d", bus.out_lane, bus.data_out);
               void'(exp_q.pop_front());
            end
         end
         check("sat_count", longint'(bus.sat_count), longint'(exp_sat));
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  longint'(bus.in_ready), 1);
      check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
      check({tag, "_data_out"},  longint'(bus.data_out), 0);
      check({tag, "_out_lane"},  longint'(bus.out_lane), 0);
      check({tag, "_sat_count"}, longint'(bus.sat_count), 0);
   endtask

   initial begin
      bit acc;
      int n_acc;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.data_in_1 = '0;
      bus.data_in_2 = '0;
      bus.data_in_3 = '0;
      bus.out_ready = 1'b1;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Basic rounding, lane order and one-cycle latency.
      drive_cycle(1'b1, 64'sd3 <<< 31, 64'sh4000_0000, 64'sh3FFF_FFFF, 1'b1, 3, 1, 0, acc);
      check("t1_accept", longint'(acc), 1);
      drain();

      // Negative round-half-up.
      drive_cycle(1'b1, -64'sh4000_0000, -64'sh4000_0001, -(64'sd5 <<< 31), 1'b1, 0, -1, -5, acc);
      drain();

      // Saturation on both rails, including the most positive input.
      drive_cycle(1'b1, 64'sd1 <<< 50, -(64'sd1 <<< 50), 64'sh7FFF_FFFF_FFFF_FFFF,
                  1'b1, 32767, -32768, 32767, acc);
      drain();
      check("t3_sat_count", longint'(bus.sat_count), 3);

      // Backpressure: third back-to-back block is dropped.
      ready_force = 1'b0;
      idle(1);
      n_acc = 0;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, longint'(10 * i + 1) <<< 31, longint'(10 * i + 2) <<< 31,
                     longint'(10 * i + 3) <<< 31, 1'b0, 0, 0, 0, acc);
         n_acc += int'(acc);
      end
      check("t4_accepted_blocks", n_acc, 2);
      idle(4);
      ready_force = 1'b1;
      drain();

      // Push lands on the same edge as the last-lane pop.
      drive_cycle(1'b1, 64'sd7 <<< 31, 64'sd8 <<< 31, 64'sd9 <<< 31, 1'b0, 0, 0, 0, acc);
      idle(2);
      drive_cycle(1'b1, -(64'sd7 <<< 31), -(64'sd8 <<< 31), -(64'sd9 <<< 31), 1'b0, 0, 0, 0, acc);
      check("t5_accept", longint'(acc), 1);
      drain();

      // Reset mid-block discards buffered samples.
      ready_force = 1'b0;
      drive_cycle(1'b1, 64'sd100 <<< 31, 64'sd1 <<< 50, 64'sd102 <<< 31, 1'b0, 0, 0, 0, acc);
      idle(2);
      check("t6_pre_valid", longint'(bus.out_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      exp_q.delete();
      exp_sat = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      ready_force = 1'b1;
      idle(5);
      drive_cycle(1'b1, 64'sd42 <<< 31, 64'sd43 <<< 31, 64'sd44 <<< 31, 1'b1, 42, 43, 44, acc);
      drain();

      // Randomized traffic with random sink backpressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
         drive_cycle(1'($urandom_range(0, 3) != 0), rand_val(), rand_val(), rand_val(),
                     1'b0, 0, 0, 0, acc);
      end
      rand_ready  = 1'b0;
      ready_force = 1'b1;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, limit %0d", 2000000);
      $fatal(1);
   end
endmodule
